// File: rtl/cmp_word_seq_pkg.sv
// ============================================================================
// Module   : cmp_word_seq_pkg
// Brief    : Shared state encodings and cascade constants for cmp_word_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_word_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Cascade ordering is {eq, gt, lt}; an empty prefix compares as equal.
  localparam logic [2:0] CASCADE_INIT = 3'b100;

endpackage

`default_nettype wire

// File: rtl/cmp_word_seq_compa8bit.sv
// ============================================================================
// Module   : compa8bit
// Brief    : 8-bit cascadable magnitude comparator, purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module compa8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       aeqb,
  output logic       agtb,
  output logic       altb,
  input  logic       aeqbin,
  input  logic       agtbin,
  input  logic       altbin
);

  // This byte outranks the cascade; only an equal byte lets the cascade through.
  always_comb begin
    aeqb = 1'b0;
    agtb = 1'b0;
    altb = 1'b0;
    if (a > b) begin
      agtb = 1'b1;
    end else if (a < b) begin
      altb = 1'b1;
    end else begin
      aeqb = aeqbin;
      agtb = agtbin;
      altb = altbin;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cmp_word_seq.sv
// ============================================================================
// Module   : cmp_word_seq
// Brief    : Byte-serial (LSB first) magnitude comparator sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_word_seq
  import cmp_word_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic       aeqb,
  output logic       agtb,
  output logic       altb
);

  localparam int             CW   = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0]  LAST = CW'(NBYTES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    casc_q, casc_d;
  logic [2:0]    res_q, res_d;
  logic          cmp_eq, cmp_gt, cmp_lt;
  logic          xfer;

  compa8bit u_compa8bit (
    .a      (a_byte),
    .b      (b_byte),
    .aeqb   (cmp_eq),
    .agtb   (cmp_gt),
    .altb   (cmp_lt),
    .aeqbin (casc_q[2]),
    .agtbin (casc_q[1]),
    .altbin (casc_q[0])
  );

  assign xfer = byte_valid && (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    casc_d  = casc_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          casc_d  = CASCADE_INIT;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          casc_d = {cmp_eq, cmp_gt, cmp_lt};
          cnt_d  = cnt_q + CW'(1);
          // Result is captured with the final byte so it is visible alongside done.
          if (cnt_q == LAST) begin
            res_d   = {cmp_eq, cmp_gt, cmp_lt};
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        if (start) begin
          casc_d  = CASCADE_INIT;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      casc_q  <= CASCADE_INIT;
      res_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      casc_q  <= casc_d;
      res_q   <= res_d;
    end
  end

  assign byte_ready = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_FIN);
  assign aeqb       = res_q[2];
  assign agtb       = res_q[1];
  assign altb       = res_q[0];

endmodule

`default_nettype wire
